pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter block for the 5-stage pipelined MIPS core. It holds the architectural PC and computes the next PC from sequential flow, conditional branches (BEQ/BNE/BLTZ) and jumps (J/JAL/JR). It also produces the instruction-ROM word address. Branch and jump controls arrive from the stage that resolves them; `pcand4` is the PC+4 of that resolving instruction.

## Interface
- `WIDTH`, default 32: datapath and PC width.
- `ADDR_W`, default 10: instruction-memory word-address width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk`  in  1: single clock; PC updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: PC load enable; 0 holds the PC (stall).
- `Beq`, `Bne`, `BLTZ`  in  1 each: branch-type decodes of the resolving instruction.
- `JMP`  in  1: any jump (J, JAL, JR).
- `JR`  in  1: register-indirect jump.
- `JAL`  in  1: link jump; has no effect inside this block beyond `JMP`.
- `SH`  in  1: reserved; ignored.
- `AluEqual`  in  1: ALU operand equality flag.
- `R1`  in  WIDTH: rs register value (JR target, BLTZ operand).
- `I_imm`  in  WIDTH: sign-extended 16-bit branch offset.
- `J_imm`  in  WIDTH: zero-extended 26-bit jump index.
- `pcand4`  in  WIDTH: PC+4 of the resolving instruction.
- `branch_ok`  out  1: branch taken (flush request to the pipeline).
- `pc_out`  out  WIDTH: current PC register.
- `normal_pc`  out  WIDTH: `pc_out + 4`.
- `addr`  out  ADDR_W: `pc_out[ADDR_W+1:2]`.

## Operation
- `bltz_taken = BLTZ & ($signed(R1) < 0)`, which equals `R1[31]`.
- `branch_ok = (Beq & AluEqual) | (Bne & ~AluEqual) | bltz_taken`.
- `branch_pc = pcand4 + (I_imm << 2)`. The result is modulo 2^WIDTH; overflow is discarded.
- `j_pc = J_imm << 2`. This is the full 32-bit value; the upper PC bits are not concatenated.
- Next-PC priority, from highest to lowest:
  - `JMP`: use `R1` if `JR`, else `j_pc`.
  - `branch_ok`: use `branch_pc`.
  - otherwise: use `normal_pc`.
- `JMP` overrides a simultaneously true branch condition. `branch_ok` is still asserted in that case.
- `JR` without `JMP` has no effect.
- All outputs except `pc_out` are purely combinational.

## Timing
- `pc_out` loads `next_pc` on each rising `clk` edge while `enable=1`. It holds while `enable=0`, and the combinational outputs stay live during the hold.
- On `rst=0` the PC is asynchronously set to `RESET_PC`, regardless of `clk` and `enable`. Consequently `addr=0`, `normal_pc=4`, and `pc_out=0` in the default configuration.
- The first load occurs on the first rising edge after `rst` deasserts.
- A taken branch or jump redirects the fetch one cycle later, at the next edge.
- A redirect presented while `enable=0` is lost unless the controls are still valid when `enable` returns to 1.
- `addr` wraps naturally: a PC of 0x1000 gives `addr=0`.

## Structure
- Shared package `mips_pkg`: `XLEN=32`, `IMEM_ADDR_W=10`, `RESET_PC`.
- Sub-modules:
  - `mux2`: parameterized 2:1 mux; instantiate 4×.
  - `cmp_lt`: signed less-than.
  - `dff_en_ar`: enable register with asynchronous active-low reset.
- The top level contains only wiring, two adders and the branch logic.

## Test plan
- **Reset:** `rst=0` mid-cycle → `pc_out=0` immediately and `addr=0`. After release with no controls, 3 edges → `pc_out=0x0C`, `addr=3`.
- **Stall:** `enable=0` for 2 edges at `pc_out=0x10` → stays 0x10 and `normal_pc=0x14`.
- **BEQ/BNE:**
  - `Beq=1`, `AluEqual=1`, `pcand4=0x20`, `I_imm=0xFFFFFFFE` → `branch_ok=1`; next PC 0x18.
  - `Bne=1`, `AluEqual=1` → `branch_ok=0`; next PC = `pc_out+4`.
- **BLTZ:**
  - `R1=0x80000000` → taken, target = `pcand4 + (I_imm<<2)`.
  - `R1=0` or `0x7FFFFFFF` → not taken.
- **Jumps:**
  - `JMP=1`, `J_imm=0x40` → next PC 0x100.
  - `JMP=1`, `JR=1`, `R1=0x3C` → next PC 0x3C.
  - `JMP=1` with `Beq=1`, `AluEqual=1` → jump target wins and `branch_ok=1`.
- **Wrap:** `pcand4=0xFFFFFFFC`, `I_imm=1`, `Beq=1`, `AluEqual=1` → next PC 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================
// mips_pkg : shared core-wide widths and reset constants
// Rev 1.0
// ============================================================
`default_nettype none

package mips_pkg;
  localparam int             XLEN        = 32;
  localparam int             IMEM_ADDR_W = 10;
  localparam logic [XLEN-1:0] RESET_PC   = '0;
endpackage

`default_nettype wire

// File: rtl/cmp_lt.sv
// ============================================================
// cmp_lt : two's-complement signed less-than comparator
// Rev 1.0
// ============================================================
`default_nettype none

module cmp_lt #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt
);
  assign lt = $signed(a) < $signed(b);
endmodule

`default_nettype wire

// File: rtl/dff_en_ar.sv
// ============================================================
// dff_en_ar : load-enable register, asynchronous active-low reset
// Rev 1.0
// ============================================================
`default_nettype none

module dff_en_ar #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/mux2.sv
// ============================================================
// mux2 : parameterized 2:1 multiplexer (sel=1 picks in1)
// Rev 1.0
// ============================================================
`default_nettype none

module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? in1 : in0;
endmodule

`default_nettype wire

// File: rtl/pc_next_unit.sv
// ============================================================
// pc_next_unit : architectural PC register and next-PC selection
// Rev 1.0
// ============================================================
`default_nettype none

module pc_next_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = XLEN,
  parameter int               ADDR_W   = IMEM_ADDR_W,
  parameter logic [WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              Beq,
  input  logic              Bne,
  input  logic              BLTZ,
  input  logic              JMP,
  input  logic              JR,
  input  logic              JAL,
  input  logic              SH,
  input  logic              AluEqual,
  input  logic [WIDTH-1:0]  R1,
  input  logic [WIDTH-1:0]  I_imm,
  input  logic [WIDTH-1:0]  J_imm,
  input  logic [WIDTH-1:0]  pcand4,
  output logic              branch_ok,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  normal_pc,
  output logic [ADDR_W-1:0] addr
);
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] j_pc;
  logic [WIDTH-1:0] jump_pc;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] next_pc;
  logic             r1_neg;
  logic             bltz_taken;
  logic             unused_ctrl;

  // JAL only matters to the link-register write path; SH is reserved.
  assign unused_ctrl = JAL ^ SH;

  assign normal_pc = pc_out + WIDTH'(4);
  assign branch_pc = pcand4 + (I_imm << 2);
  // Plain index shift: upper PC bits are deliberately not spliced in.
  assign j_pc      = J_imm << 2;
  assign addr      = pc_out[ADDR_W+1:2];

  cmp_lt #(.WIDTH(WIDTH)) u_r1_lt_zero (
    .a  (R1),
    .b  ('0),
    .lt (r1_neg)
  );

  mux2 #(.WIDTH(1)) u_bltz_gate (
    .sel (BLTZ),
    .in0 (1'b0),
    .in1 (r1_neg),
    .y   (bltz_taken)
  );

  assign branch_ok = (Beq & AluEqual) | (Bne & ~AluEqual) | bltz_taken;

  mux2 #(.WIDTH(WIDTH)) u_jump_sel (
    .sel (JR),
    .in0 (j_pc),
    .in1 (R1),
    .y   (jump_pc)
  );

  mux2 #(.WIDTH(WIDTH)) u_branch_sel (
    .sel (branch_ok),
    .in0 (normal_pc),
    .in1 (branch_pc),
    .y   (seq_pc)
  );

  // Jumps take priority over a simultaneously taken branch.
  mux2 #(.WIDTH(WIDTH)) u_next_sel (
    .sel (JMP),
    .in0 (seq_pc),
    .in1 (jump_pc),
    .y   (next_pc)
  );

  dff_en_ar #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst),
    .en    (enable),
    .d     (next_pc),
    .q     (pc_out)
  );
endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// ============================================================
// tb_pc_next_unit : directed self-checking bench for pc_next_unit
// Rev 1.0
// ============================================================
`default_nettype none

module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        Beq, Bne, BLTZ, JMP, JR, JAL, SH, AluEqual;
  logic [31:0] R1, I_imm, J_imm, pcand4;
  logic        branch_ok;
  logic [31:0] pc_out, normal_pc;
  logic [9:0]  addr;

  int checks   = 0;
  int failures = 0;

  pc_next_unit dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .Beq       (Beq),
    .Bne       (Bne),
    .BLTZ      (BLTZ),
    .JMP       (JMP),
    .JR        (JR),
    .JAL       (JAL),
    .SH        (SH),
    .AluEqual  (AluEqual),
    .R1        (R1),
    .I_imm     (I_imm),
    .J_imm     (J_imm),
    .pcand4    (pcand4),
    .branch_ok (branch_ok),
    .pc_out    (pc_out),
    .normal_pc (normal_pc),
    .addr      (addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    Beq = 0; Bne = 0; BLTZ = 0; JMP = 0; JR = 0; JAL = 0; SH = 0; AluEqual = 0;
    R1 = '0; I_imm = '0; J_imm = '0; pcand4 = '0;
  endtask

  initial begin
    clear_ctrl();
    enable = 1;
    rst    = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    tick(); tick();
    chk("run_before_reset", pc_out, 32'h8);

    // asynchronous reset mid-cycle
    #1 rst = 0;
    #1;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_addr", {22'd0, addr}, 32'h0);
    chk("reset_normal_pc", normal_pc, 32'h4);
    @(negedge clk);
    rst = 1;
    tick(); tick(); tick();
    chk("seq_3_pc", pc_out, 32'h0C);
    chk("seq_3_addr", {22'd0, addr}, 32'h3);

    // stall
    tick();
    chk("seq_4_pc", pc_out, 32'h10);
    enable = 0;
    tick(); tick();
    chk("stall_pc", pc_out, 32'h10);
    chk("stall_normal_pc", normal_pc, 32'h14);
    enable = 1;

    // BEQ taken, negative offset
    Beq = 1; AluEqual = 1; pcand4 = 32'h20; I_imm = 32'hFFFF_FFFE;
    #1;
    chk("beq_branch_ok", {31'd0, branch_ok}, 32'h1);
    tick();
    chk("beq_target", pc_out, 32'h18);

    // BNE not taken
    clear_ctrl();
    Bne = 1; AluEqual = 1; pcand4 = 32'h80; I_imm = 32'h10;
    #1;
    chk("bne_branch_ok", {31'd0, branch_ok}, 32'h0);
    tick();
    chk("bne_seq", pc_out, 32'h1C);

    // BNE taken
    AluEqual = 0;
    #1;
    chk("bne_taken_ok", {31'd0, branch_ok}, 32'h1);
    tick();
    chk("bne_taken_pc", pc_out, 32'hC0);

    // BLTZ
    clear_ctrl();
    BLTZ = 1; R1 = 32'h8000_0000; pcand4 = 32'h100; I_imm = 32'h4;
    #1;
    chk("bltz_neg_ok", {31'd0, branch_ok}, 32'h1);
    tick();
    chk("bltz_target", pc_out, 32'h110);
    R1 = 32'h0;
    #1;
    chk("bltz_zero_ok", {31'd0, branch_ok}, 32'h0);
    R1 = 32'h7FFF_FFFF;
    #1;
    chk("bltz_maxpos_ok", {31'd0, branch_ok}, 32'h0);
    tick();
    chk("bltz_not_taken_pc", pc_out, 32'h114);

    // redirect presented only while stalled is lost
    clear_ctrl();
    enable = 0;
    Beq = 1; AluEqual = 1; pcand4 = 32'h40;
    #1;
    chk("stall_branch_ok_live", {31'd0, branch_ok}, 32'h1);
    tick();
    chk("stall_redirect_held", pc_out, 32'h114);
    clear_ctrl();
    enable = 1;
    tick();
    chk("stall_redirect_lost", pc_out, 32'h118);

    // jumps
    JMP = 1; J_imm = 32'h40;
    tick();
    chk("j_target", pc_out, 32'h100);
    JR = 1; R1 = 32'h3C;
    tick();
    chk("jr_target", pc_out, 32'h3C);
    JMP = 0; JR = 1; R1 = 32'h200;
    tick();
    chk("jr_without_jmp", pc_out, 32'h40);
    clear_ctrl();
    JMP = 1; J_imm = 32'h40; Beq = 1; AluEqual = 1; pcand4 = 32'h500;
    #1;
    chk("jmp_beq_branch_ok", {31'd0, branch_ok}, 32'h1);
    tick();
    chk("jmp_over_branch", pc_out, 32'h100);
    clear_ctrl();
    JAL = 1; SH = 1;
    tick();
    chk("jal_sh_ignored", pc_out, 32'h104);

    // wrap cases
    clear_ctrl();
    Beq = 1; AluEqual = 1; pcand4 = 32'hFFFF_FFFC; I_imm = 32'h1;
    tick();
    chk("branch_wrap", pc_out, 32'h0);
    clear_ctrl();
    JMP = 1; J_imm = 32'h400;
    tick();
    chk("addr_wrap_pc", pc_out, 32'h1000);
    chk("addr_wrap_addr", {22'd0, addr}, 32'h0);
    clear_ctrl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
